// File: rtl/hword_responder_if.sv
// Bus bundle between the bridge's 16-bit initiator port and the halfword responder.
interface hword_responder_if;
  logic [63:0] adr_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        siz_i;
  logic        signed_i;
  logic [15:0] dat_i;
  logic        ack_o;
  logic        err_o;
  logic [15:0] dat_o;

  modport master (
    output adr_i, cyc_i, stb_i, we_i, siz_i, signed_i, dat_i,
    input  ack_o, err_o, dat_o
  );

  modport slave (
    input  adr_i, cyc_i, stb_i, we_i, siz_i, signed_i, dat_i,
    output ack_o, err_o, dat_o
  );
endinterface

// File: rtl/hword_responder.sv
// Halfword memory responder: byte/halfword transfers served from an internal
// RAM split into byte lanes, with a fixed number of wait states before ack.

// One byte lane of the RAM: synchronous write, combinational read.
module hword_lane_ram #(
  parameter int ADDR_BITS = 10,
  parameter int VEC_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] idx_i,
  input  logic [VEC_W-1:0]     wdat_i,
  output logic [VEC_W-1:0]     rdat_o
);
  logic [VEC_W-1:0] mem [2**ADDR_BITS];

  // RAM contents survive reset, so no reset term here.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdat_i;
  end

  assign rdat_o = mem[idx_i];
endmodule

module hword_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  hword_responder_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS:0]    adr_q;
  logic                  we_q, siz_q, err_q;
  logic [15:0]           wdat_q, rdat_q;

  logic                  start, commit, mis;
  logic [ADDR_BITS:0]    cur_adr;
  logic                  cur_we, cur_siz;
  logic [15:0]           cur_dat;
  logic [ADDR_BITS-1:0]  idx;

  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_wdat, lane_rdat;

  logic unused_bits;
  assign unused_bits = ^{bus.adr_i[63:ADDR_BITS+1], bus.signed_i};

  assign start = (state_q == S_IDLE) && bus.cyc_i && bus.stb_i;

  // With zero wait states the commit edge is the sampling edge, so the
  // request must come straight from the bus rather than the latches.
  assign cur_adr = start ? bus.adr_i[ADDR_BITS:0] : adr_q;
  assign cur_we  = start ? bus.we_i  : we_q;
  assign cur_siz = start ? bus.siz_i : siz_q;
  assign cur_dat = start ? bus.dat_i : wdat_q;

  assign idx    = cur_adr[ADDR_BITS:1];
  assign mis    = cur_siz & cur_adr[0];
  assign commit = (state_d == S_DONE);

  // Next-state and wait counter; an abort in WAIT returns to IDLE silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!bus.cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      siz_q   <= 1'b0;
      wdat_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        adr_q  <= bus.adr_i[ADDR_BITS:0];
        we_q   <= bus.we_i;
        siz_q  <= bus.siz_i;
        wdat_q <= bus.dat_i;
      end
    end
  end

  // Per-lane write enables: halfword hits both lanes, byte hits the lane
  // picked by adr[0]; a byte always travels on dat_i[7:0].
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_we[l]   = commit & cur_we & ~mis & (cur_siz | (cur_adr[0] == 1'(l)));
    assign lane_wdat[l] = cur_siz ? cur_dat[l*VEC_W +: VEC_W] : cur_dat[VEC_W-1:0];

    hword_lane_ram #(.ADDR_BITS(ADDR_BITS), .VEC_W(VEC_W)) u_ram (
      .clk_i  (clk_i),
      .we_i   (lane_we[l]),
      .idx_i  (idx),
      .wdat_i (lane_wdat[l]),
      .rdat_o (lane_rdat[l])
    );
  end

  // Read data and error flag exist only during DONE; both clear on leaving it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdat_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= commit & mis;
      if (commit && !cur_we && !mis)
        rdat_q <= cur_siz ? lane_rdat : {8'h00, (cur_adr[0] ? lane_rdat[1] : lane_rdat[0])};
      else
        rdat_q <= 16'd0;
    end
  end

  assign bus.ack_o = (state_q == S_DONE) & ~err_q & bus.cyc_i & bus.stb_i;
  assign bus.err_o = (state_q == S_DONE) &  err_q & bus.cyc_i & bus.stb_i;
  assign bus.dat_o = rdat_q;
endmodule

// File: tb/tb_hword_responder.sv
// Scoreboard bench: two responders (1 and 3 wait states) share one stimulus
// stream; `sel` picks which one is observed.
module tb_hword_responder;
  logic        clk_i, reset_i;
  logic [63:0] adr;
  logic        cyc, stb, we, siz, sgn;
  logic [15:0] wdat;

  hword_responder_if bus_a ();
  hword_responder_if bus_b ();

  assign bus_a.adr_i = adr;  assign bus_b.adr_i = adr;
  assign bus_a.cyc_i = cyc;  assign bus_b.cyc_i = cyc;
  assign bus_a.stb_i = stb;  assign bus_b.stb_i = stb;
  assign bus_a.we_i  = we;   assign bus_b.we_i  = we;
  assign bus_a.siz_i = siz;  assign bus_b.siz_i = siz;
  assign bus_a.signed_i = sgn; assign bus_b.signed_i = sgn;
  assign bus_a.dat_i = wdat; assign bus_b.dat_i = wdat;

  hword_responder #(.ADDR_BITS(10), .WAIT_STATES(1)) u_dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus_a.slave));
  hword_responder #(.ADDR_BITS(10), .WAIT_STATES(3)) u_dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus_b.slave));

  logic        sel;
  logic        ack_s, err_s;
  logic [15:0] dat_s;
  assign ack_s = sel ? bus_b.ack_o : bus_a.ack_o;
  assign err_s = sel ? bus_b.err_o : bus_a.err_o;
  assign dat_s = sel ? bus_b.dat_o : bus_a.dat_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc_n = 0;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  int n_chk = 0, n_err = 0, resp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        we, siz;
    logic [63:0] adr;
    logic [15:0] wdat;
    logic        err, cmp_dat;
    logic [15:0] rdat;
  } req_t;

  typedef struct {
    logic        err, cmp_dat;
    logic [15:0] dat;
    int          due;
  } exp_t;

  req_t req_q[$];
  exp_t sb[$];

  localparam logic [63:0] BASE = 64'h4444_3333_2222_1110;

  task automatic add(input logic w, input logic s, input logic [63:0] a, input logic [15:0] d,
                     input logic e, input logic c, input logic [15:0] r);
    req_t t;
    t.we = w; t.siz = s; t.adr = a; t.wdat = d; t.err = e; t.cmp_dat = c; t.rdat = r;
    req_q.push_back(t);
  endtask

  // Drive queued requests back to back, stb held, advancing on each ack/err.
  task automatic run();
    req_t r;
    exp_t e;
    logic got;
    @(posedge clk_i); #1;
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      cyc = 1'b1; stb = 1'b1; we = r.we; siz = r.siz; adr = r.adr; wdat = r.wdat;
      sgn = ~sgn;
      e.err = r.err; e.cmp_dat = r.cmp_dat; e.dat = r.rdat;
      e.due = cyc_n + 1 + (sel ? 3 : 1);
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk_i);
        if (ack_s || err_s) got = 1'b1;
      end
      chk("resp_timeout", 64'(got), 64'd1);
      if (!got) sb.delete(sb.size() - 1);
      @(posedge clk_i); #1;
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Response monitor: every ack/err must match the oldest outstanding request.
  always @(negedge clk_i) begin
    exp_t e;
    if (ack_s || err_s) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", {62'd0, ack_s, err_s}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("err", 64'(err_s), 64'(e.err));
        chk("ack", 64'(ack_s), 64'(!e.err));
        if (e.cmp_dat) chk("dat", 64'(dat_s), 64'(e.dat));
        chk("latency", 64'(cyc_n), 64'(e.due));
      end
    end
  end

  initial begin
    exp_t e;
    logic got;
    int   n0;
    reset_i = 1'b0; cyc = 0; stb = 0; we = 0; siz = 0; sgn = 0; adr = '0; wdat = '0;
    sel = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack_a", 64'(bus_a.ack_o), 64'd0);
    chk("rst_err_a", 64'(bus_a.err_o), 64'd0);
    chk("rst_dat_a", 64'(bus_a.dat_o), 64'd0);
    chk("rst_ack_b", 64'(bus_b.ack_o), 64'd0);
    chk("rst_err_b", 64'(bus_b.err_o), 64'd0);
    chk("rst_dat_b", 64'(bus_b.dat_o), 64'd0);
    reset_i = 1'b1;

    // 3 wait states: reset during WAIT drops the write.
    add(1, 1, 64'h6, 16'h1111, 0, 0, 16'h0);
    run();
    @(posedge clk_i); #1;
    cyc = 1; stb = 1; we = 1; siz = 1; adr = 64'h6; wdat = 16'h1234;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_i = 1'b0; #1;
    chk("rstw_ack", 64'(bus_b.ack_o), 64'd0);
    chk("rstw_err", 64'(bus_b.err_o), 64'd0);
    chk("rstw_dat", 64'(bus_b.dat_o), 64'd0);
    cyc = 0; stb = 0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    add(0, 1, 64'h6, 16'h0, 0, 1, 16'h1111);
    run();

    // Reset in DONE kills ack and read data at once.
    @(posedge clk_i); #1;
    cyc = 1; stb = 1; we = 0; siz = 1; adr = 64'h6;
    e.err = 0; e.cmp_dat = 1; e.dat = 16'h1111; e.due = cyc_n + 4;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (ack_s) got = 1'b1;
    end
    chk("rstd_seen", 64'(got), 64'd1);
    #2 reset_i = 1'b0; #1;
    chk("rstd_ack", 64'(bus_b.ack_o), 64'd0);
    chk("rstd_dat", 64'(bus_b.dat_o), 64'd0);
    cyc = 0; stb = 0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;

    // 1 wait state from here on.
    sel = 1'b0;
    add(1, 1, BASE + 2, 16'hBEEF, 0, 0, 16'h0);
    add(0, 1, BASE + 2, 16'h0,    0, 1, 16'hBEEF);
    add(1, 0, BASE + 3, 16'h55AA, 0, 0, 16'h0);
    add(0, 1, BASE + 2, 16'h0,    0, 1, 16'hAAEF);
    add(0, 0, BASE + 2, 16'h0,    0, 1, 16'h00EF);
    add(0, 0, BASE + 3, 16'h0,    0, 1, 16'h00AA);
    add(0, 1, 64'h0000_0000_0000_0112, 16'h0, 0, 1, 16'hAAEF);
    add(1, 1, BASE + 0, 16'h0123, 0, 0, 16'h0);
    add(0, 1, BASE + 1, 16'h0,    1, 1, 16'h0);
    add(1, 1, BASE + 1, 16'hFFFF, 1, 1, 16'h0);
    add(0, 1, BASE + 0, 16'h0,    0, 1, 16'h0123);
    add(0, 1, BASE + 2, 16'h0,    0, 1, 16'hAAEF);
    add(1, 1, BASE + 4, 16'h7777, 0, 0, 16'h0);
    run();

    // Abort: cyc dropped in WAIT.
    @(posedge clk_i); #1;
    n0 = resp_cnt;
    cyc = 1; stb = 1; we = 1; siz = 1; adr = BASE + 4; wdat = 16'h5555;
    @(posedge clk_i); #1;
    cyc = 0; stb = 0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("abort_quiet", 64'(resp_cnt - n0), 64'd0);
    add(0, 1, BASE + 4, 16'h0, 0, 1, 16'h7777);
    run();

    // Back-to-back bursts, as the bridge splits a dword.
    add(1, 1, BASE + 14, 16'hDEAD, 0, 0, 16'h0);
    add(1, 1, BASE + 12, 16'hBEEF, 0, 0, 16'h0);
    add(1, 1, BASE + 10, 16'hFEED, 0, 0, 16'h0);
    add(1, 1, BASE + 8,  16'hFACE, 0, 0, 16'h0);
    run();
    add(0, 1, BASE + 14, 16'h0, 0, 1, 16'hDEAD);
    add(0, 1, BASE + 12, 16'h0, 0, 1, 16'hBEEF);
    add(0, 1, BASE + 10, 16'h0, 0, 1, 16'hFEED);
    add(0, 1, BASE + 8,  16'h0, 0, 1, 16'hFACE);
    run();

    repeat (4) @(posedge clk_i);
    #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
